// File: rtl/iter_fft_addr_gen_pkg.sv
// ============================================================================
// Module  : iter_fft_pkg
// Purpose : Shared FSM encoding, default size and address helper functions
//           for the iterative radix-2 DIT FFT address sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package iter_fft_pkg;

  localparam int DEFAULT_LOG2N = 10;

  // Sequencer phases. S_GAP only exists when the inter-stage gap is built in.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Butterfly index k with a zero bit inserted at position s (upper input).
  function automatic logic [31:0] insert_zero(input logic [31:0] k, input logic [31:0] s);
    logic [31:0] low;
    low = (32'd1 << s) - 32'd1;
    return ((k & ~low) << 1) | (k & low);
  endfunction

  // Twiddle index: (k mod 2^s) scaled up to the full (log2n-1)-bit ROM range.
  function automatic logic [31:0] tw_index(input logic [31:0] k, input logic [31:0] s,
                                           input logic [31:0] log2n);
    logic [31:0] low;
    logic [31:0] mask;
    low  = (32'd1 << s) - 32'd1;
    mask = (32'd1 << (log2n - 32'd1)) - 32'd1;
    return ((k & low) << (log2n - 32'd1 - s)) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iter_fft_addr_gen_if.sv
// ============================================================================
// Module  : iter_fft_addr_gen_if
// Purpose : Start request plus address/status bundle of the FFT sequencer.
//           master = consumer/controller side, slave = sequencer side.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface iter_fft_addr_gen_if
  import iter_fft_pkg::*;
#(
  parameter int LOG2N = DEFAULT_LOG2N,
  parameter int STW   = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N)
);

  logic             i_START;
  logic [LOG2N-1:0] o_ADDR_A;
  logic [LOG2N-1:0] o_ADDR_B;
  logic [LOG2N-2:0] o_TW_ADDR;
  logic [STW-1:0]   o_STAGE;
  logic             o_VALID;
  logic             o_STAGE_LAST;
  logic             o_BUSY;
  logic             o_DONE;

  modport master (
    output i_START,
    input  o_ADDR_A, o_ADDR_B, o_TW_ADDR, o_STAGE,
    input  o_VALID, o_STAGE_LAST, o_BUSY, o_DONE
  );

  modport slave (
    input  i_START,
    output o_ADDR_A, o_ADDR_B, o_TW_ADDR, o_STAGE,
    output o_VALID, o_STAGE_LAST, o_BUSY, o_DONE
  );

endinterface

`default_nettype wire

// File: rtl/iter_fft_addr_gen_stage_cnt.sv
// ============================================================================
// Module  : iter_fft_stage_cnt
// Purpose : Nested stage (s) / butterfly (k) counter. k runs 0..N/2-1 inside
//           each stage; s runs 0..LOG2N-1 and wraps to 0 after the last stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module iter_fft_stage_cnt
  import iter_fft_pkg::*;
#(
  parameter int LOG2N = DEFAULT_LOG2N,
  parameter int STW   = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             adv,
  output logic [STW-1:0]   s,
  output logic [LOG2N-2:0] k,
  output logic             k_last,
  output logic             s_last
);

  assign k_last = &k;
  assign s_last = (s == STW'(LOG2N - 1));

  // Advance k each step; on k wrap move to the next stage (or wrap the stage).
  always_ff @(posedge clk) begin
    if (!rst) begin
      s <= '0;
      k <= '0;
    end else if (en) begin
      if (clr) begin
        s <= '0;
        k <= '0;
      end else if (adv) begin
        if (k_last) begin
          k <= '0;
          s <= s_last ? '0 : s + 1'b1;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/iter_fft_addr_gen.sv
// ============================================================================
// Module  : iter_fft_addr_gen
// Purpose : Address/control sequencer for an in-place radix-2 DIT FFT. Emits
//           one butterfly (A, B, twiddle, stage) per enabled cycle.
//           Optional macro ITER_FFT_STAGE_GAP_EN inserts GAP_CYCLES idle
//           cycles between stages so the butterfly pipeline can drain.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module iter_fft_addr_gen
  import iter_fft_pkg::*;
#(
  parameter int LOG2N      = DEFAULT_LOG2N,
  parameter int STW        = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N),
  parameter int GAP_CYCLES = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  iter_fft_addr_gen_if.slave  bus
);

  localparam int KW = LOG2N - 1;

  // The counter always holds the butterfly that will be issued next, so the
  // output registers load straight from it on the issuing edge.
  state_t           state;
  logic [STW-1:0]   cnt_s;
  logic [KW-1:0]    cnt_k;
  logic             k_last;
  logic             s_last;
  logic             cnt_clr;
  logic             issue;
  logic             gap_go;
  logic             final_issued;

  logic [LOG2N-1:0] addr_a_nxt;
  logic [LOG2N-1:0] addr_b_nxt;
  logic [KW-1:0]    tw_nxt;

  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;
  logic [KW-1:0]    tw;
  logic [STW-1:0]   stage;
  logic             valid;
  logic             stage_last;
  logic             busy;
  logic             done;

`ifdef ITER_FFT_STAGE_GAP_EN
  localparam int GW = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  logic [GW-1:0] gap_cnt;
  logic          gap_end;
  assign gap_go  = (GAP_CYCLES > 0) && stage_last;
  assign gap_end = (gap_cnt == GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0));
`else
  assign gap_go  = 1'b0;
`endif

  iter_fft_stage_cnt #(
    .LOG2N (LOG2N),
    .STW   (STW)
  ) u_cnt (
    .clk    (CLK),
    .rst    (RST),
    .en     (EN),
    .clr    (cnt_clr),
    .adv    (issue),
    .s      (cnt_s),
    .k      (cnt_k),
    .k_last (k_last),
    .s_last (s_last)
  );

  assign cnt_clr    = (state == S_DONE);
  assign addr_a_nxt = LOG2N'(insert_zero(32'(cnt_k), 32'(cnt_s)));
  assign addr_b_nxt = addr_a_nxt | (LOG2N'(1) << cnt_s);
  assign tw_nxt     = KW'(tw_index(32'(cnt_k), 32'(cnt_s), 32'(LOG2N)));

  // Decide whether a butterfly is issued on the coming edge.
  always_comb begin
    issue = 1'b0;
    case (state)
      S_IDLE:  issue = bus.i_START;
      S_RUN:   issue = !final_issued && !gap_go;
`ifdef ITER_FFT_STAGE_GAP_EN
      S_GAP:   issue = gap_end;
`endif
      default: issue = 1'b0;
    endcase
  end

  // FSM and registered outputs; the state always describes what is shown.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= S_IDLE;
      final_issued <= 1'b0;
      addr_a       <= '0;
      addr_b       <= '0;
      tw           <= '0;
      stage        <= '0;
      valid        <= 1'b0;
      stage_last   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef ITER_FFT_STAGE_GAP_EN
      gap_cnt      <= '0;
`endif
    end else if (EN) begin
      if (issue) begin
        addr_a       <= addr_a_nxt;
        addr_b       <= addr_b_nxt;
        tw           <= tw_nxt;
        stage        <= cnt_s;
        stage_last   <= k_last;
        final_issued <= k_last && s_last;
        valid        <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (issue) begin
            state <= S_RUN;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
            valid <= 1'b0;
          end
        end
        S_RUN: begin
          if (final_issued) begin
            state        <= S_DONE;
            final_issued <= 1'b0;
            valid        <= 1'b0;
            done         <= 1'b1;
          end else if (gap_go) begin
`ifdef ITER_FFT_STAGE_GAP_EN
            state   <= S_GAP;
            gap_cnt <= '0;
`endif
            valid   <= 1'b0;
          end
        end
`ifdef ITER_FFT_STAGE_GAP_EN
        S_GAP: begin
          if (gap_end) begin
            state <= S_RUN;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ADDR_A     = addr_a;
  assign bus.o_ADDR_B     = addr_b;
  assign bus.o_TW_ADDR    = tw;
  assign bus.o_STAGE      = stage;
  assign bus.o_VALID      = valid;
  assign bus.o_STAGE_LAST = stage_last;
  assign bus.o_BUSY       = busy;
  assign bus.o_DONE       = done;

endmodule

`default_nettype wire
